// File: rtl/plaintext_checker.sv
`default_nettype none
// ============================================================================
// Module   : plaintext_checker
// Purpose  : Reads a decrypted message back from the A RAM after an arcfour
//            pass and reports whether every byte is lowercase 'a'..'z' or
//            space. On failure, it also reports the first offending index
//            and byte.
// Revision : 1.0 - initial release
// ============================================================================
module plaintext_checker #(
  parameter int MESSAGE_LENGTH     = 32,
  parameter int MESSAGE_LOG_LENGTH = 5,
  parameter int RD_LATENCY         = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic [MESSAGE_LOG_LENGTH-1:0] rd_addr,
  input  logic [7:0]                    rd_data,
  output logic                          busy,
  output logic                          done,
  output logic                          success,
  output logic [MESSAGE_LOG_LENGTH-1:0] fail_index,
  output logic [7:0]                    fail_byte
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_PASS  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  // The last address is compared directly so a full-size message never wraps.
  localparam logic [MESSAGE_LOG_LENGTH-1:0] c_last_addr =
    MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);

  state_t                          r_state;
  logic [RD_LATENCY-1:0]           r_vld;
  logic [MESSAGE_LOG_LENGTH-1:0]   r_tag [RD_LATENCY];

  logic                            w_check;
  logic [MESSAGE_LOG_LENGTH-1:0]   w_tag;
  logic                            w_legal;

  // The oldest pipeline slot lines up with rd_data for its tagged address.
  always_comb begin
    w_check = r_vld[RD_LATENCY-1];
    w_tag   = r_tag[RD_LATENCY-1];
    w_legal = (rd_data == 8'h20) || ((rd_data >= 8'h61) && (rd_data <= 8'h7A));
  end

  // Pass sequencing, the address/valid pipeline and registered result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_vld      <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_tag[i] <= '0;
      end
      rd_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      success    <= 1'b0;
      fail_index <= '0;
      fail_byte  <= 8'h00;
    end else begin
      // Every address driven during ISSUE is tagged and shifted toward the checker.
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
      r_vld[0] <= (r_state == S_ISSUE);
      r_tag[0] <= rd_addr;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            done    <= 1'b0;
            success <= 1'b0;
            busy    <= 1'b1;
            rd_addr <= '0;
            r_state <= S_ISSUE;
          end
        end

        S_ISSUE, S_DRAIN: begin
          if (w_check && !w_legal) begin
            // First bad byte wins; anything still in flight is discarded.
            fail_index <= w_tag;
            fail_byte  <= rd_data;
            r_vld      <= '0;
            r_state    <= S_FAIL;
          end else if (w_check && (w_tag == c_last_addr)) begin
            r_state <= S_PASS;
          end else if (r_state == S_ISSUE) begin
            if (rd_addr == c_last_addr) begin
              r_state <= S_DRAIN;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
        end

        S_PASS: begin
          busy       <= 1'b0;
          done       <= 1'b1;
          success    <= 1'b1;
          fail_index <= '0;
          fail_byte  <= 8'h00;
          r_state    <= S_IDLE;
        end

        S_FAIL: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          success <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_plaintext_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_plaintext_checker
// Purpose  : Self-checking bench for plaintext_checker. Three instances share
//            one message store: 32 bytes with read latency 1, 32 bytes with
//            read latency 2, and 1 byte with read latency 1. Each is compared
//            against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_plaintext_checker;

  localparam int c_len [3] = '{32, 32, 1};
  localparam int c_lat [3] = '{1, 2, 1};

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] mem [32];

  logic [4:0] a0, a1, fi0, fi1;
  logic [0:0] a2, fi2;
  logic [7:0] q0, q1a, q1b, q2, fb0, fb1, fb2;
  logic       b0, b1, b2, d0, d1, d2, s0, s1, s2;

  plaintext_checker #(.MESSAGE_LENGTH(32), .MESSAGE_LOG_LENGTH(5), .RD_LATENCY(1)) u0 (
    .clk(clk), .reset(reset), .start(start), .rd_addr(a0), .rd_data(q0),
    .busy(b0), .done(d0), .success(s0), .fail_index(fi0), .fail_byte(fb0));

  plaintext_checker #(.MESSAGE_LENGTH(32), .MESSAGE_LOG_LENGTH(5), .RD_LATENCY(2)) u1 (
    .clk(clk), .reset(reset), .start(start), .rd_addr(a1), .rd_data(q1b),
    .busy(b1), .done(d1), .success(s1), .fail_index(fi1), .fail_byte(fb1));

  plaintext_checker #(.MESSAGE_LENGTH(1), .MESSAGE_LOG_LENGTH(1), .RD_LATENCY(1)) u2 (
    .clk(clk), .reset(reset), .start(start), .rd_addr(a2), .rd_data(q2),
    .busy(b2), .done(d2), .success(s2), .fail_index(fi2), .fail_byte(fb2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM read ports with one or two cycles of latency.
  always @(posedge clk) begin
    q0  <= mem[a0];
    q1a <= mem[a1];
    q1b <= q1a;
    q2  <= mem[{4'd0, a2}];
  end

  logic [2:0] done_v, busy_v, succ_v;
  logic [4:0] addr_v [3];
  logic [4:0] fidx_v [3];
  logic [7:0] fbyte_v [3];
  assign done_v = {d2, d1, d0};
  assign busy_v = {b2, b1, b0};
  assign succ_v = {s2, s1, s0};
  assign addr_v[0] = a0;
  assign addr_v[1] = a1;
  assign addr_v[2] = {4'd0, a2};
  assign fidx_v[0] = fi0;
  assign fidx_v[1] = fi1;
  assign fidx_v[2] = {4'd0, fi2};
  assign fbyte_v[0] = fb0;
  assign fbyte_v[1] = fb1;
  assign fbyte_v[2] = fb2;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit is_legal(input logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  function automatic logic [7:0] rand_legal();
    int r;
    r = $urandom_range(0, 26);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  function automatic logic [7:0] rand_illegal();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (is_legal(b));
    return b;
  endfunction

  task automatic fill(input logic [7:0] b);
    for (int i = 0; i < 32; i++) mem[i] = b;
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s/u%0d/busy", name, i), busy_v[i], 0);
      check($sformatf("%s/u%0d/done", name, i), done_v[i], 0);
      check($sformatf("%s/u%0d/success", name, i), succ_v[i], 0);
      check($sformatf("%s/u%0d/rd_addr", name, i), addr_v[i], 0);
      check($sformatf("%s/u%0d/fail_index", name, i), fidx_v[i], 0);
      check($sformatf("%s/u%0d/fail_byte", name, i), fbyte_v[i], 0);
    end
  endtask

  // Pulses start on the current negedge and follows all three instances to done.
  task automatic run_pass(input string name);
    int         exp_lat [3];
    bit         exp_ok  [3];
    int         exp_idx [3];
    logic [7:0] exp_b   [3];
    int         got_lat [3];
    bit         busy_ok [3];
    bit         addr_ok [3];
    int         prev    [3];
    int         cyc;

    for (int i = 0; i < 3; i++) begin
      exp_ok[i]  = 1'b1;
      exp_idx[i] = 0;
      exp_b[i]   = 8'h00;
      exp_lat[i] = c_len[i] + c_lat[i] + 1;
      for (int k = 0; k < c_len[i]; k++) begin
        if (!is_legal(mem[k])) begin
          exp_ok[i]  = 1'b0;
          exp_idx[i] = k;
          exp_b[i]   = mem[k];
          exp_lat[i] = k + c_lat[i] + 2;
          break;
        end
      end
      got_lat[i] = 0;
      busy_ok[i] = 1'b1;
      addr_ok[i] = 1'b1;
    end

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s/u%0d/done_drop", name, i), done_v[i], 0);
      check($sformatf("%s/u%0d/busy_rise", name, i), busy_v[i], 1);
      check($sformatf("%s/u%0d/addr_start", name, i), addr_v[i], 0);
      prev[i] = int'(addr_v[i]);
    end

    cyc = 0;
    while (cyc < 150 && !(got_lat[0] != 0 && got_lat[1] != 0 && got_lat[2] != 0)) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (got_lat[i] == 0) begin
          if (done_v[i]) got_lat[i] = cyc;
          else begin
            if (!busy_v[i]) busy_ok[i] = 1'b0;
            if (int'(addr_v[i]) != prev[i] && int'(addr_v[i]) != prev[i] + 1) addr_ok[i] = 1'b0;
            prev[i] = int'(addr_v[i]);
          end
        end
      end
    end

    for (int i = 0; i < 3; i++) begin
      if (exp_ok[i])
        check($sformatf("%s/u%0d/latency", name, i), got_lat[i], exp_lat[i]);
      else
        check($sformatf("%s/u%0d/latency_le_%0d", name, i, exp_lat[i]),
              (got_lat[i] != 0 && got_lat[i] >= exp_lat[i] - 1 && got_lat[i] <= exp_lat[i]), 1);
      check($sformatf("%s/u%0d/success", name, i), succ_v[i], exp_ok[i]);
      check($sformatf("%s/u%0d/fail_index", name, i), fidx_v[i], exp_idx[i]);
      check($sformatf("%s/u%0d/fail_byte", name, i), fbyte_v[i], exp_b[i]);
      check($sformatf("%s/u%0d/busy_end", name, i), busy_v[i], 0);
      check($sformatf("%s/u%0d/busy_held", name, i), busy_ok[i], 1);
      check($sformatf("%s/u%0d/addr_steps", name, i), addr_ok[i], 1);
      if (exp_ok[i])
        check($sformatf("%s/u%0d/addr_final", name, i), addr_v[i], c_len[i] - 1);
    end
  endtask

  initial begin
    logic [7:0] bound_ok  [3];
    logic [7:0] bound_bad [4];
    int         nbad;
    bound_ok  = '{8'h20, 8'h61, 8'h7A};
    bound_bad = '{8'h60, 8'h7B, 8'h1F, 8'hFF};

    reset = 1'b0;
    start = 1'b0;
    fill(8'h61);
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    fill(8'h61);
    run_pass("all_a");

    fill(8'h61);
    mem[5] = 8'h41;
    mem[9] = 8'h00;
    run_pass("upper5");

    for (int j = 0; j < 3; j++) begin
      fill(8'h61);
      mem[$urandom_range(0, 31)] = bound_ok[j];
      run_pass($sformatf("bound_ok_%0h", bound_ok[j]));
    end

    for (int j = 0; j < 4; j++) begin
      fill(8'h61);
      mem[31] = bound_bad[j];
      run_pass($sformatf("bound_bad_%0h", bound_bad[j]));
    end

    fill(8'h61);
    mem[0] = 8'h60;
    mem[1] = 8'h41;
    run_pass("bad_idx0");

    // Reset in the middle of a pass, between clock edges.
    for (int i = 0; i < 32; i++) mem[i] = rand_legal();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("midreset/u0/busy_before", b0, 1);
    check("midreset/u0/addr_before", (a0 != 5'd0), 1);
    #2 reset = 1'b0;
    #1 check_all_zero("midreset_async");
    repeat (3) @(negedge clk);
    check("midreset/u0/no_done", d0, 0);
    check("midreset/u1/no_done", d1, 0);
    reset = 1'b1;
    @(negedge clk);
    run_pass("after_reset");

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 32; i++) mem[i] = rand_legal();
      if ($urandom_range(0, 1) == 1) begin
        nbad = $urandom_range(1, 3);
        for (int n = 0; n < nbad; n++) mem[$urandom_range(0, 31)] = rand_illegal();
      end
      run_pass($sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
